// File: rtl/duel_pkg.sv
// Shared types, state encoding and keypad codes for the two-player duel core.
package duel_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [3:0] KEY_P1_DN   = 4'h0;
  localparam logic [3:0] KEY_P2_UP   = 4'h3;
  localparam logic [3:0] KEY_P1_UP   = 4'h5;
  localparam logic [3:0] KEY_P2_DN   = 4'h9;
  localparam logic [3:0] KEY_P1_FIRE = 4'hA;
  localparam logic [3:0] KEY_P2_FIRE = 4'hB;
  localparam logic [3:0] KEY_START   = 4'hF;

  // 1-D span test; incl selects touching-counts (<=) versus strict (<) overlap.
  function automatic logic span_overlap(coord_t a, coord_t aw, coord_t b, coord_t bw, logic incl);
    if (incl) return (a <= b + bw) && (b <= a + aw);
    return (a < b + bw) && (b < a + aw);
  endfunction

endpackage

// File: rtl/duel_if.sv
// Keypad-in / render-out bundle between the keypad driver, the duel core and the VGA renderers.
interface duel_if import duel_pkg::*; #(
  parameter int NB = 2
);
  logic             key_valid;
  logic [3:0]       key_code;
  coord_t           p1_y;
  coord_t           p2_y;
  logic [NB*11-1:0] b1_x;
  logic [NB*11-1:0] b1_y;
  logic [NB-1:0]    b1_act;
  logic [NB*11-1:0] b2_x;
  logic [NB*11-1:0] b2_y;
  logic [NB-1:0]    b2_act;
  logic [7:0]       score1;
  logic [7:0]       score2;
  state_e           state;
  logic [1:0]       winner;

  modport master (
    output key_valid, key_code,
    input  p1_y, p2_y, b1_x, b1_y, b1_act, b2_x, b2_y, b2_act, score1, score2, state, winner
  );

  modport slave (
    input  key_valid, key_code,
    output p1_y, p2_y, b1_x, b1_y, b1_act, b2_x, b2_y, b2_act, score1, score2, state, winner
  );
endinterface

// File: rtl/duel_bullet_bank.sv
// One player's bullet slots: lowest-free allocation on fire, per-tick advance or kill.
module duel_bullet_bank import duel_pkg::*; #(
  parameter int NB  = 2,
  parameter int DIR = 1,
  parameter int VEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic             fire,
  input  coord_t           spawn_x,
  input  coord_t           spawn_y,
  input  logic [NB-1:0]    kill,
  output logic [NB*11-1:0] x,
  output logic [NB*11-1:0] y,
  output logic [NB-1:0]    act,
  output logic             full
);

  logic [NB-1:0] spawn_sel;

  always_comb begin
    spawn_sel = '0;
    full      = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (!act[i] && full) begin
        spawn_sel[i] = 1'b1;
        full         = 1'b0;
      end
    end
  end

  // A freshly spawned slot was inactive, so it can never also be advanced or killed.
  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      act <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (clear) begin
          act[i] <= 1'b0;
        end else if (fire && spawn_sel[i]) begin
          act[i]        <= 1'b1;
          x[i*11 +: 11] <= spawn_x;
          y[i*11 +: 11] <= spawn_y;
        end else if (advance && act[i]) begin
          if (kill[i])      act[i]        <= 1'b0;
          else if (DIR > 0) x[i*11 +: 11] <= x[i*11 +: 11] + coord_t'(VEL);
          else              x[i*11 +: 11] <= x[i*11 +: 11] - coord_t'(VEL);
        end
      end
    end
  end

endmodule

// File: rtl/duel_engine.sv
// Duel game core: paddles, two bullet banks, collision/scoring and the match FSM.
// Define DUEL_FIRE_COOLDOWN_EN to add an 8-tick per-player fire cooldown.
// state | meaning
// IDLE  | after reset, waiting for the start key
// PLAY  | match running: keys move/fire, bullets resolve on each tick
// OVER  | a player reached WIN_SCORE; start key replays
module duel_engine import duel_pkg::*; #(
  parameter int NB         = 2,
  parameter int TICK_DIV   = 50_000,
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 480,
  parameter int MARGIN_TOP = 60,
  parameter int P1_X       = 25,
  parameter int P2_X       = 565,
  parameter int PLAYER_Y0  = 80,
  parameter int PLAYER_W   = 50,
  parameter int BULLET_W   = 5,
  parameter int WALL1_X    = 5,
  parameter int WALL2_X    = 625,
  parameter int WALL_W     = 10,
  parameter int VEL_P      = 10,
  parameter int VEL_B      = 1,
  parameter int WIN_SCORE  = 20
) (
  input logic   clk,
  input logic   rst,
  duel_if.slave bus
);

  localparam int         TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam coord_t     C_Y0    = coord_t'(PLAYER_Y0);
  localparam coord_t     C_PW    = coord_t'(PLAYER_W);
  localparam coord_t     C_BW    = coord_t'(BULLET_W);
  localparam coord_t     C_P1X   = coord_t'(P1_X);
  localparam coord_t     C_P2X   = coord_t'(P2_X);
  localparam coord_t     C_TOP   = coord_t'(MARGIN_TOP);
  localparam coord_t     C_YMAX  = coord_t'(Y_MAX);
  localparam coord_t     C_VP    = coord_t'(VEL_P);
  localparam coord_t     C_HALF  = coord_t'(X_MAX / 2);
  localparam coord_t     C_W1_IN = coord_t'(WALL1_X + WALL_W);
  localparam coord_t     C_W2X   = coord_t'(WALL2_X);
  localparam coord_t     C_B1_X0 = coord_t'(P1_X + PLAYER_W);
  localparam coord_t     C_B2_X0 = coord_t'(P2_X - BULLET_W);
  localparam coord_t     C_MID   = coord_t'(PLAYER_W / 2);
  localparam logic [7:0] C_WIN   = 8'(WIN_SCORE);

  state_e           state_q, state_d;
  coord_t           p1_q, p1_d, p2_q, p2_d;
  logic [7:0]       s1_q, s1_d, s2_q, s2_d;
  logic [8:0]       sum1, sum2;
  logic [1:0]       win_q, win_d;
  logic             key_v_q;
  logic [3:0]       key_c_q;
  logic [TW-1:0]    tick_cnt;
  logic             tick, advance, clear, start;
  logic             fire1, fire2, cd1_ok, cd2_ok, b1_full, b2_full;
  logic [NB*11-1:0] b1_x, b1_y, b2_x, b2_y;
  logic [NB-1:0]    b1_act, b2_act, kill1, kill2;
  logic [3:0]       inc1, inc2;

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign advance = tick && (state_q == ST_PLAY);
  assign clear   = (state_d != ST_PLAY);
  assign sum1    = {1'b0, s1_q} + {5'b0, inc1};
  assign sum2    = {1'b0, s2_q} + {5'b0, inc2};

  always_ff @(posedge clk) begin
    if (rst) begin
      key_v_q  <= 1'b0;
      key_c_q  <= '0;
      tick_cnt <= '0;
    end else begin
      key_v_q  <= bus.key_valid;
      key_c_q  <= bus.key_code;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  // Collisions on current positions; bullet pairs first, then player block, then wall.
  always_comb begin
    kill1 = '0;
    kill2 = '0;
    inc1  = '0;
    inc2  = '0;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < NB; j++) begin
        if (b1_act[i] && b2_act[j] && !kill1[i] && !kill2[j]
            && span_overlap(b1_x[i*11 +: 11], C_BW, b2_x[j*11 +: 11], C_BW, 1'b0)
            && span_overlap(b1_y[i*11 +: 11], C_BW, b2_y[j*11 +: 11], C_BW, 1'b0)) begin
          kill1[i] = 1'b1;
          kill2[j] = 1'b1;
          if (((b1_x[i*11 +: 11] + b2_x[j*11 +: 11] + C_BW) >> 1) >= C_HALF) inc1 = inc1 + 4'd1;
          else                                                                inc2 = inc2 + 4'd1;
        end
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (b1_act[i] && !kill1[i]) begin
        if (span_overlap(b1_x[i*11 +: 11], C_BW, C_P2X, C_PW, 1'b1)
            && span_overlap(b1_y[i*11 +: 11], C_BW, p2_q, C_PW, 1'b1)) begin
          kill1[i] = 1'b1;
        end else if (b1_x[i*11 +: 11] + C_BW >= C_W2X) begin
          kill1[i] = 1'b1;
          inc1     = inc1 + 4'd2;
        end
      end
      if (b2_act[i] && !kill2[i]) begin
        if (span_overlap(b2_x[i*11 +: 11], C_BW, C_P1X, C_PW, 1'b1)
            && span_overlap(b2_y[i*11 +: 11], C_BW, p1_q, C_PW, 1'b1)) begin
          kill2[i] = 1'b1;
        end else if (b2_x[i*11 +: 11] <= C_W1_IN) begin
          kill2[i] = 1'b1;
          inc2     = inc2 + 4'd2;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    start   = 1'b0;
    fire1   = 1'b0;
    fire2   = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (key_v_q) begin
          case (key_c_q)
            KEY_P1_UP:   if (p1_q > C_TOP)         p1_d = p1_q - C_VP;
            KEY_P1_DN:   if (p1_q + C_PW < C_YMAX) p1_d = p1_q + C_VP;
            KEY_P2_UP:   if (p2_q > C_TOP)         p2_d = p2_q - C_VP;
            KEY_P2_DN:   if (p2_q + C_PW < C_YMAX) p2_d = p2_q + C_VP;
            KEY_P1_FIRE: fire1 = cd1_ok;
            KEY_P2_FIRE: fire2 = cd2_ok;
            default:     ;
          endcase
        end
        if (tick) begin
          s1_d = sum1[8] ? 8'hFF : sum1[7:0];
          s2_d = sum2[8] ? 8'hFF : sum2[7:0];
        end
        if (s1_d >= C_WIN || s2_d >= C_WIN) begin
          state_d = ST_OVER;
          win_d   = (s1_d >= C_WIN) ? 2'd1 : 2'd2;
        end
      end
      default: begin
        if (key_v_q && key_c_q == KEY_START) begin
          start   = 1'b1;
          state_d = ST_PLAY;
          p1_d    = C_Y0;
          p2_d    = C_Y0;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p1_q    <= C_Y0;
      p2_q    <= C_Y0;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
    end
  end

`ifdef DUEL_FIRE_COOLDOWN_EN
  logic [3:0] cd1_q, cd2_q;

  assign cd1_ok = (cd1_q == '0);
  assign cd2_ok = (cd2_q == '0);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cd1_q <= '0;
      cd2_q <= '0;
    end else begin
      if (fire1 && !b1_full)          cd1_q <= 4'd8;
      else if (tick && cd1_q != '0)   cd1_q <= cd1_q - 4'd1;
      if (fire2 && !b2_full)          cd2_q <= 4'd8;
      else if (tick && cd2_q != '0)   cd2_q <= cd2_q - 4'd1;
    end
  end
`else
  assign cd1_ok = 1'b1;
  assign cd2_ok = 1'b1;
`endif

  duel_bullet_bank #(.NB(NB), .DIR(1), .VEL(VEL_B)) u_bank1 (
    .clk(clk), .rst(rst), .clear(clear), .advance(advance), .fire(fire1),
    .spawn_x(C_B1_X0), .spawn_y(p1_q + C_MID), .kill(kill1),
    .x(b1_x), .y(b1_y), .act(b1_act), .full(b1_full)
  );

  duel_bullet_bank #(.NB(NB), .DIR(-1), .VEL(VEL_B)) u_bank2 (
    .clk(clk), .rst(rst), .clear(clear), .advance(advance), .fire(fire2),
    .spawn_x(C_B2_X0), .spawn_y(p2_q + C_MID), .kill(kill2),
    .x(b2_x), .y(b2_y), .act(b2_act), .full(b2_full)
  );

  assign bus.p1_y   = p1_q;
  assign bus.p2_y   = p2_q;
  assign bus.b1_x   = b1_x;
  assign bus.b1_y   = b1_y;
  assign bus.b1_act = b1_act;
  assign bus.b2_x   = b2_x;
  assign bus.b2_y   = b2_y;
  assign bus.b2_act = b2_act;
  assign bus.score1 = s1_q;
  assign bus.score2 = s2_q;
  assign bus.state  = state_q;
  assign bus.winner = win_q;

endmodule

// File: tb/tb_duel_engine.sv
// Directed + random bench for duel_engine against a slot-array game model.
module tb_duel_engine;
  import duel_pkg::*;

  localparam int NB = 2, TICK_DIV = 8, WIN = 4;
  localparam int X_MAX = 640, Y_MAX = 480, TOP = 60, P1_X = 25, P2_X = 565, Y0 = 80;
  localparam int PW = 50, BW = 5, W1 = 5, W2 = 625, WW = 10, VP = 10, VB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  duel_if #(.NB(NB)) bus ();
  duel_engine #(.NB(NB), .TICK_DIV(TICK_DIV), .WIN_SCORE(WIN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // game model state
  int m_st, m_p1, m_p2, m_s1, m_s2, m_win, m_tc, m_cd1, m_cd2;
  bit m_pv;
  logic [3:0] m_pc;
  int m_b1x[NB], m_b1y[NB], m_b2x[NB], m_b2y[NB];
  bit m_b1a[NB], m_b2a[NB];
  logic [3:0] codes[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_p1 = Y0; m_p2 = Y0; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_tc = 0; m_pv = 0; m_pc = 0; m_cd1 = 0; m_cd2 = 0;
    for (int i = 0; i < NB; i++) begin m_b1a[i] = 0; m_b2a[i] = 0; end
  endtask

  function automatic bit ov(int a, int aw, int b, int bw, bit incl);
    if (incl) return (a <= b + bw) && (b <= a + aw);
    return (a < b + bw) && (b < a + aw);
  endfunction

  task automatic model_edge(input bit kv, input logic [3:0] kc, input bit r);
    bit tk, av, started;
    bit d1[NB], d2[NB];
    logic [3:0] ac;
    int f1, f2, i1, i2, p1o, p2o;
    if (r) begin model_reset(); return; end
    tk = (m_tc == TICK_DIV - 1);
    m_tc = tk ? 0 : m_tc + 1;
    av = m_pv; ac = m_pc; m_pv = kv; m_pc = kc;
    p1o = m_p1; p2o = m_p2;
    f1 = -1; f2 = -1; started = 0;
    if (m_st == 1) begin
      if (av && ac == KEY_P1_FIRE && m_cd1 == 0)
        for (int i = 0; i < NB; i++) if (!m_b1a[i] && f1 < 0) f1 = i;
      if (av && ac == KEY_P2_FIRE && m_cd2 == 0)
        for (int i = 0; i < NB; i++) if (!m_b2a[i] && f2 < 0) f2 = i;
      i1 = 0; i2 = 0;
      if (tk) begin
        for (int i = 0; i < NB; i++) begin d1[i] = 0; d2[i] = 0; end
        for (int i = 0; i < NB; i++)
          for (int j = 0; j < NB; j++)
            if (m_b1a[i] && m_b2a[j] && !d1[i] && !d2[j] &&
                ov(m_b1x[i], BW, m_b2x[j], BW, 0) && ov(m_b1y[i], BW, m_b2y[j], BW, 0)) begin
              d1[i] = 1; d2[j] = 1;
              if ((m_b1x[i] + m_b2x[j] + BW) / 2 >= X_MAX / 2) i1++; else i2++;
            end
        for (int i = 0; i < NB; i++) begin
          if (m_b1a[i] && !d1[i]) begin
            if (ov(m_b1x[i], BW, P2_X, PW, 1) && ov(m_b1y[i], BW, p2o, PW, 1)) d1[i] = 1;
            else if (m_b1x[i] + BW >= W2) begin d1[i] = 1; i1 += 2; end
          end
          if (m_b2a[i] && !d2[i]) begin
            if (ov(m_b2x[i], BW, P1_X, PW, 1) && ov(m_b2y[i], BW, p1o, PW, 1)) d2[i] = 1;
            else if (m_b2x[i] <= W1 + WW) begin d2[i] = 1; i2 += 2; end
          end
        end
        for (int i = 0; i < NB; i++) begin
          if (m_b1a[i]) begin if (d1[i]) m_b1a[i] = 0; else m_b1x[i] += VB; end
          if (m_b2a[i]) begin if (d2[i]) m_b2a[i] = 0; else m_b2x[i] -= VB; end
        end
        m_s1 = (m_s1 + i1 > 255) ? 255 : m_s1 + i1;
        m_s2 = (m_s2 + i2 > 255) ? 255 : m_s2 + i2;
      end
      if (av) begin
        if (ac == KEY_P1_UP && p1o > TOP) m_p1 = p1o - VP;
        if (ac == KEY_P1_DN && p1o + PW < Y_MAX) m_p1 = p1o + VP;
        if (ac == KEY_P2_UP && p2o > TOP) m_p2 = p2o - VP;
        if (ac == KEY_P2_DN && p2o + PW < Y_MAX) m_p2 = p2o + VP;
      end
      if (f1 >= 0) begin m_b1a[f1] = 1; m_b1x[f1] = P1_X + PW; m_b1y[f1] = p1o + PW / 2; end
      if (f2 >= 0) begin m_b2a[f2] = 1; m_b2x[f2] = P2_X - BW; m_b2y[f2] = p2o + PW / 2; end
      if (m_s1 >= WIN || m_s2 >= WIN) begin
        m_st = 2; m_win = (m_s1 >= WIN) ? 1 : 2;
        for (int i = 0; i < NB; i++) begin m_b1a[i] = 0; m_b2a[i] = 0; end
      end
    end else if (av && ac == KEY_START) begin
      started = 1;
      m_st = 1; m_p1 = Y0; m_p2 = Y0; m_s1 = 0; m_s2 = 0; m_win = 0;
    end
`ifdef DUEL_FIRE_COOLDOWN_EN
    if (started) begin m_cd1 = 0; m_cd2 = 0; end
    else begin
      if (f1 >= 0) m_cd1 = 8; else if (tk && m_cd1 > 0) m_cd1--;
      if (f2 >= 0) m_cd2 = 8; else if (tk && m_cd2 > 0) m_cd2--;
    end
`endif
  endtask

  task automatic step(input bit kv, input logic [3:0] kc);
    bus.key_valid = kv;
    bus.key_code  = kc;
    @(posedge clk);
    model_edge(kv, kc, rst);
    #1;
  endtask

  task automatic press(input logic [3:0] kc);
    step(1'b1, kc);
    step(1'b0, 4'h0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"}, bus.state, m_st);
    chk({tag, ":winner"}, bus.winner, m_win);
    chk({tag, ":score1"}, bus.score1, m_s1);
    chk({tag, ":score2"}, bus.score2, m_s2);
    chk({tag, ":p1_y"}, bus.p1_y, m_p1);
    chk({tag, ":p2_y"}, bus.p2_y, m_p2);
    for (int i = 0; i < NB; i++) begin
      chk({tag, ":b1_act"}, bus.b1_act[i], m_b1a[i]);
      chk({tag, ":b2_act"}, bus.b2_act[i], m_b2a[i]);
      if (m_b1a[i]) begin
        chk({tag, ":b1_x"}, bus.b1_x[i*11 +: 11], m_b1x[i]);
        chk({tag, ":b1_y"}, bus.b1_y[i*11 +: 11], m_b1y[i]);
      end
      if (m_b2a[i]) begin
        chk({tag, ":b2_x"}, bus.b2_x[i*11 +: 11], m_b2x[i]);
        chk({tag, ":b2_y"}, bus.b2_y[i*11 +: 11], m_b2y[i]);
      end
    end
  endtask

  function automatic bit done_cond(int kind, int idx);
    bit any;
    any = 0;
    for (int i = 0; i < NB; i++) any |= m_b1a[i] | m_b2a[i];
    case (kind)
      0:       return !m_b1a[idx];
      1:       return m_st != 1;
      default: return !any;
    endcase
  endfunction

  task automatic run_until(input int kind, input int idx, input int budget, input string tag);
    int n;
    bit timed_out;
    n = 0;
    while (!done_cond(kind, idx) && n < budget) begin
      step(1'b0, 4'h0);
      if (n % 64 == 63) check_all(tag);
      n++;
    end
    timed_out = !done_cond(kind, idx);
    chk({tag, ":timeout"}, timed_out, 0);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ":state"}, bus.state, 0);
    chk({tag, ":p1_y"}, bus.p1_y, Y0);
    chk({tag, ":p2_y"}, bus.p2_y, Y0);
    chk({tag, ":b1_act"}, bus.b1_act, 0);
    chk({tag, ":b2_act"}, bus.b2_act, 0);
    chk({tag, ":b1_x"}, bus.b1_x, 0);
    chk({tag, ":b1_y"}, bus.b1_y, 0);
    chk({tag, ":b2_x"}, bus.b2_x, 0);
    chk({tag, ":b2_y"}, bus.b2_y, 0);
    chk({tag, ":scores"}, {bus.score1, bus.score2}, 0);
    chk({tag, ":winner"}, bus.winner, 0);
  endtask

  initial begin
    logic [3:0] kc;
    int r;
    codes = '{KEY_P1_UP, KEY_P1_DN, KEY_P2_UP, KEY_P2_DN, KEY_P1_FIRE, KEY_P2_FIRE, KEY_START, 4'h7};
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    model_reset();

    do_reset();
    check_reset_values("reset");

    // paddle motion and the top margin
    press(KEY_START);
    chk("s1_state", bus.state, 1);
    repeat (3) press(KEY_P1_DN);
    chk("s1_p1_down", bus.p1_y, 110);
    repeat (5) press(KEY_P1_UP);
    chk("s1_p1_at_top", bus.p1_y, 60);
    press(KEY_P1_UP);
    chk("s1_p1_stop", bus.p1_y, 60);
    check_all("s1");

    // P1 bullet reaches the far wall
    do_reset();
    press(KEY_START);
    repeat (12) press(KEY_P2_DN);
    press(KEY_P1_FIRE);
    chk("s2_fired", bus.b1_act, 1);
    run_until(0, 0, 6000, "s2");
    chk("s2_score1", bus.score1, 2);
    chk("s2_act", bus.b1_act, 0);

    // P2 paddle blocks the bullet
    do_reset();
    press(KEY_START);
    press(KEY_P1_FIRE);
    run_until(0, 0, 6000, "s3");
    chk("s3_score1", bus.score1, 0);
    chk("s3_act", bus.b1_act, 0);

    // slot exhaustion and reuse of the lowest free slot
    do_reset();
    press(KEY_START);
    press(KEY_P1_FIRE);
    repeat (6) press(KEY_P1_DN);
    press(KEY_P1_FIRE);
    press(KEY_P1_FIRE);
    chk("s4_full", bus.b1_act, 3);
    check_all("s4a");
    run_until(0, 0, 6000, "s4b");
    chk("s4_slot0_free", bus.b1_act, 2);
    press(KEY_P1_FIRE);
    chk("s4_reuse", bus.b1_act, 3);
    chk("s4_reuse_y", bus.b1_y[10:0], 165);
    check_all("s4c");

    // head-on bullets meet mid-field
    do_reset();
    press(KEY_START);
    step(1'b1, KEY_P1_FIRE);
    step(1'b1, KEY_P2_FIRE);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    chk("s5_both", {bus.b1_act[0], bus.b2_act[0]}, 3);
    run_until(2, 0, 4000, "s5");
    chk("s5_sum", bus.score1 + bus.score2, 1);

    // match end, replay, reset mid-match
    do_reset();
    press(KEY_START);
    repeat (12) press(KEY_P2_DN);
    press(KEY_P1_FIRE);
    repeat (20) step(1'b0, 4'h0);
    press(KEY_P1_FIRE);
    run_until(0, 0, 6000, "s6a");
    chk("s6_first_hit", bus.score1, 2);
    press(KEY_P1_FIRE);
    run_until(1, 0, 6000, "s6b");
    chk("s6_over", bus.state, 2);
    chk("s6_winner", bus.winner, 1);
    chk("s6_score1", bus.score1, 4);
    chk("s6_cleared", bus.b1_act, 0);
    press(KEY_START);
    chk("s6_replay", bus.state, 1);
    chk("s6_replay_sc", {bus.score1, bus.score2, 6'd0, bus.winner}, 0);
    press(KEY_P1_FIRE);
    press(KEY_P2_FIRE);
    repeat (5) step(1'b0, 4'h0);
    do_reset();
    check_reset_values("s6_rst");

    // random key stream against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 999);
      rst = (r < 2);
      if (r % 5 < 2) begin
        kc = codes[$urandom_range(0, 7)];
        step(1'b1, kc);
      end else begin
        step(1'b0, 4'h0);
      end
      if (n % 16 == 15) check_all("rand");
    end
    rst = 1'b0;
    check_all("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
